// File: rtl/fsm_sequencer.sv
// Next-state sequencer for the RV32I multicycle core: registered 5-bit control state,
// memory-stall watchdog, and retire/illegal/timeout status pulses.
module fsm_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic [2:0]       funct3,
  input  logic             mem_ready,
  output logic [4:0]       state,
  output logic             illegal_instr,
  output logic             mem_timeout,
  output logic             retired,
  output logic [CNT_W-1:0] retire_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(MEM_TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (MEM_TIMEOUT != 0);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  // Encodings are fixed because the downstream control decoder keys on them.
  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_MEMADR = 5'd2,
    S_MEMRD  = 5'd3,
    S_LDWB   = 5'd4,
    S_SW     = 5'd5,
    S_REXE   = 5'd6,
    S_ALUWB  = 5'd7,
    S_BEQ    = 5'd8,
    S_IEXE   = 5'd9,
    S_IWB    = 5'd10,
    S_JAL    = 5'd11,
    S_JALR   = 5'd12,
    S_SB     = 5'd13,
    S_SH     = 5'd14,
    S_BNE    = 5'd15,
    S_BLT    = 5'd16,
    S_BGE    = 5'd17,
    S_BLTU   = 5'd18,
    S_BGEU   = 5'd19,
    S_AUIPC  = 5'd20,
    S_LUI    = 5'd21
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              illegal_d, timeout_d, retire_d;

  always_comb begin
    state_d   = S_FETCH;
    wait_d    = '0;
    illegal_d = 1'b0;
    timeout_d = 1'b0;
    retire_d  = 1'b0;

    case (state_q)
      S_FETCH: state_d = S_DECODE;

      S_DECODE: begin
        case (opcode)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_REXE;
          OP_ITYPE:          state_d = S_IEXE;
          OP_JAL:            state_d = S_JAL;
          OP_JALR:           state_d = S_JALR;
          OP_AUIPC:          state_d = S_AUIPC;
          OP_LUI:            state_d = S_LUI;
          OP_BRANCH: begin
            case (funct3)
              3'b000:  state_d = S_BEQ;
              3'b001:  state_d = S_BNE;
              3'b100:  state_d = S_BLT;
              3'b101:  state_d = S_BGE;
              3'b110:  state_d = S_BLTU;
              3'b111:  state_d = S_BGEU;
              default: illegal_d = 1'b1;
            endcase
          end
          default: illegal_d = 1'b1;
        endcase
      end

      S_MEMADR: begin
        if (opcode == OP_LOAD) begin
          case (funct3)
            3'b000, 3'b001, 3'b010, 3'b100, 3'b101: state_d = S_MEMRD;
            default: illegal_d = 1'b1;
          endcase
        end else if (opcode == OP_STORE) begin
          case (funct3)
            3'b000:  state_d = S_SB;
            3'b001:  state_d = S_SH;
            3'b010:  state_d = S_SW;
            default: illegal_d = 1'b1;
          endcase
        end else begin
          illegal_d = 1'b1;
        end
      end

      // mem_ready is checked before the watchdog so a late acknowledge still completes.
      S_MEMRD, S_SW, S_SB, S_SH: begin
        if (mem_ready) begin
          if (state_q == S_MEMRD) state_d = S_LDWB;
          else                    retire_d = 1'b1;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LIMIT)) begin
          timeout_d = 1'b1;
        end else begin
          state_d = state_q;
          wait_d  = wait_q + WAIT_W'(1);
        end
      end

      S_REXE: state_d = S_ALUWB;
      S_IEXE: state_d = S_IWB;

      S_LDWB, S_ALUWB, S_IWB, S_JAL, S_JALR, S_AUIPC, S_LUI,
      S_BEQ, S_BNE, S_BLT, S_BGE, S_BLTU, S_BGEU: retire_d = 1'b1;

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FETCH;
      wait_q        <= '0;
      illegal_instr <= 1'b0;
      mem_timeout   <= 1'b0;
      retired       <= 1'b0;
      retire_count  <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      illegal_instr <= illegal_d;
      mem_timeout   <= timeout_d;
      retired       <= retire_d;
      if (retire_d) retire_count <= retire_count + CNT_W'(1);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fsm_sequencer.sv
// Directed self-checking bench for fsm_sequencer: default, no-watchdog and 4-bit-counter
// instances run in lockstep from shared stimulus.
module tb_fsm_sequencer;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_BAD    = 7'b1111111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  opcode = '0;
  logic [2:0]  funct3 = '0;
  logic        mem_ready = 1'b1;

  logic [4:0]  state, nt_state, c4_state;
  logic        illegal_instr, mem_timeout, retired;
  logic        nt_illegal, nt_timeout, nt_retired;
  logic        c4_illegal, c4_timeout, c4_retired;
  logic [31:0] retire_count, nt_count;
  logic [3:0]  c4_count;

  int checks = 0;
  int fails = 0;
  int exp_count = 0;

  fsm_sequencer #(.CNT_W(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .state(state), .illegal_instr(illegal_instr), .mem_timeout(mem_timeout),
    .retired(retired), .retire_count(retire_count));

  fsm_sequencer #(.CNT_W(32), .MEM_TIMEOUT(0)) dut_nt (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .state(nt_state), .illegal_instr(nt_illegal), .mem_timeout(nt_timeout),
    .retired(nt_retired), .retire_count(nt_count));

  fsm_sequencer #(.CNT_W(4), .MEM_TIMEOUT(16)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .mem_ready(mem_ready),
    .state(c4_state), .illegal_instr(c4_illegal), .mem_timeout(c4_timeout),
    .retired(c4_retired), .retire_count(c4_count));

  always #5 clk = ~clk;

  // Outputs are sampled 1ns after the rising edge, inputs change at the same point.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    step();
    step();
    checks++; if (state !== 5'd0) begin fails++; $display("[TB] FAIL reset_state: got %0d expected 0", state); end
    checks++; if (retired !== 1'b0) begin fails++; $display("[TB] FAIL reset_retired: got %b expected 0", retired); end
    checks++; if (illegal_instr !== 1'b0) begin fails++; $display("[TB] FAIL reset_illegal: got %b expected 0", illegal_instr); end
    checks++; if (mem_timeout !== 1'b0) begin fails++; $display("[TB] FAIL reset_timeout: got %b expected 0", mem_timeout); end
    checks++; if (retire_count !== 32'd0) begin fails++; $display("[TB] FAIL reset_count: got %0d expected 0", retire_count); end
    checks++; if (c4_count !== 4'd0) begin fails++; $display("[TB] FAIL reset_c4_count: got %0d expected 0", c4_count); end
    exp_count = 0;
    rst_n = 1'b1;
  endtask

  task automatic test_rtype();
    int exp_seq [4] = '{1, 6, 7, 0};
    opcode = OP_RTYPE;
    funct3 = 3'b000;
    mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (state !== 5'(exp_seq[i])) begin fails++; $display("[TB] FAIL rtype_state[%0d]: got %0d expected %0d", i, state, exp_seq[i]); end
    end
    exp_count++;
    checks++; if (retired !== 1'b1) begin fails++; $display("[TB] FAIL rtype_retired: got %b expected 1", retired); end
    checks++; if (retire_count !== 32'(exp_count)) begin fails++; $display("[TB] FAIL rtype_count: got %0d expected %0d", retire_count, exp_count); end
  endtask

  task automatic test_load();
    opcode = OP_LOAD;
    funct3 = 3'b010;
    mem_ready = 1'b1;
    step();
    checks++; if (state !== 5'd1) begin fails++; $display("[TB] FAIL load_decode: got %0d expected 1", state); end
    checks++; if (retired !== 1'b0) begin fails++; $display("[TB] FAIL load_retire_pulse: got %b expected 0", retired); end
    step();
    checks++; if (state !== 5'd2) begin fails++; $display("[TB] FAIL load_memadr: got %0d expected 2", state); end
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (state !== 5'd3) begin fails++; $display("[TB] FAIL load_memrd[%0d]: got %0d expected 3", i, state); end
      checks++; if (mem_timeout !== 1'b0) begin fails++; $display("[TB] FAIL load_no_timeout[%0d]: got %b expected 0", i, mem_timeout); end
    end
    mem_ready = 1'b1;
    step();
    checks++; if (state !== 5'd4) begin fails++; $display("[TB] FAIL load_ldwb: got %0d expected 4", state); end
    step();
    exp_count++;
    checks++; if (state !== 5'd0) begin fails++; $display("[TB] FAIL load_done: got %0d expected 0", state); end
    checks++; if (retired !== 1'b1) begin fails++; $display("[TB] FAIL load_retired: got %b expected 1", retired); end
    checks++; if (retire_count !== 32'(exp_count)) begin fails++; $display("[TB] FAIL load_count: got %0d expected %0d", retire_count, exp_count); end
  endtask

  task automatic test_branch();
    logic [2:0] f3_tab [6] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111};
    int         st_tab [6] = '{8, 15, 16, 17, 18, 19};
    logic [2:0] bad_tab [2] = '{3'b010, 3'b011};
    opcode = OP_BRANCH;
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      funct3 = f3_tab[i];
      step();
      step();
      checks++; if (state !== 5'(st_tab[i])) begin fails++; $display("[TB] FAIL branch_state f3=%b: got %0d expected %0d", f3_tab[i], state, st_tab[i]); end
      step();
      exp_count++;
      checks++; if (state !== 5'd0 || retired !== 1'b1) begin fails++; $display("[TB] FAIL branch_done f3=%b: got state %0d retired %b expected 0/1", f3_tab[i], state, retired); end
      checks++; if (retire_count !== 32'(exp_count)) begin fails++; $display("[TB] FAIL branch_count f3=%b: got %0d expected %0d", f3_tab[i], retire_count, exp_count); end
    end
    for (int i = 0; i < 2; i++) begin
      funct3 = bad_tab[i];
      step();
      checks++; if (illegal_instr !== 1'b0) begin fails++; $display("[TB] FAIL branch_bad_early f3=%b: got %b expected 0", bad_tab[i], illegal_instr); end
      step();
      checks++; if (state !== 5'd0) begin fails++; $display("[TB] FAIL branch_bad_state f3=%b: got %0d expected 0", bad_tab[i], state); end
      checks++; if (illegal_instr !== 1'b1 || retired !== 1'b0) begin fails++; $display("[TB] FAIL branch_bad_flags f3=%b: got illegal %b retired %b expected 1/0", bad_tab[i], illegal_instr, retired); end
      checks++; if (retire_count !== 32'(exp_count)) begin fails++; $display("[TB] FAIL branch_bad_count f3=%b: got %0d expected %0d", bad_tab[i], retire_count, exp_count); end
    end
  endtask

  task automatic test_timeout();
    opcode = OP_STORE;
    funct3 = 3'b000;
    mem_ready = 1'b0;
    step();
    checks++; if (illegal_instr !== 1'b0) begin fails++; $display("[TB] FAIL illegal_pulse_width: got %b expected 0", illegal_instr); end
    step();
    step();
    for (int i = 0; i < 16; i++) begin
      checks++; if (state !== 5'd13 || mem_timeout !== 1'b0) begin fails++; $display("[TB] FAIL timeout_hold[%0d]: got state %0d timeout %b expected 13/0", i, state, mem_timeout); end
      step();
    end
    checks++; if (state !== 5'd0) begin fails++; $display("[TB] FAIL timeout_state: got %0d expected 0", state); end
    checks++; if (mem_timeout !== 1'b1 || retired !== 1'b0) begin fails++; $display("[TB] FAIL timeout_flags: got timeout %b retired %b expected 1/0", mem_timeout, retired); end
    checks++; if (retire_count !== 32'(exp_count)) begin fails++; $display("[TB] FAIL timeout_count: got %0d expected %0d", retire_count, exp_count); end
    checks++; if (nt_state !== 5'd13) begin fails++; $display("[TB] FAIL nowd_state_at_16: got %0d expected 13", nt_state); end
    for (int i = 0; i < 24; i++) begin
      step();
      if (i == 0) begin
        checks++; if (mem_timeout !== 1'b0) begin fails++; $display("[TB] FAIL timeout_pulse_width: got %b expected 0", mem_timeout); end
      end
      checks++; if (nt_state !== 5'd13 || nt_timeout !== 1'b0) begin fails++; $display("[TB] FAIL nowd_hold[%0d]: got state %0d timeout %b expected 13/0", i, nt_state, nt_timeout); end
    end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    exp_count = 0;
    checks++; if (nt_state !== 5'd0) begin fails++; $display("[TB] FAIL nowd_reset: got %0d expected 0", nt_state); end
  endtask

  task automatic test_illegal_lui();
    opcode = OP_BAD;
    mem_ready = 1'b1;
    step();
    step();
    checks++; if (state !== 5'd0) begin fails++; $display("[TB] FAIL bad_op_state: got %0d expected 0", state); end
    checks++; if (illegal_instr !== 1'b1 || retired !== 1'b0) begin fails++; $display("[TB] FAIL bad_op_flags: got illegal %b retired %b expected 1/0", illegal_instr, retired); end
    opcode = OP_LUI;
    step();
    checks++; if (state !== 5'd1 || illegal_instr !== 1'b0) begin fails++; $display("[TB] FAIL lui_decode: got state %0d illegal %b expected 1/0", state, illegal_instr); end
    step();
    checks++; if (state !== 5'd21) begin fails++; $display("[TB] FAIL lui_state: got %0d expected 21", state); end
    step();
    exp_count++;
    checks++; if (state !== 5'd0 || retired !== 1'b1) begin fails++; $display("[TB] FAIL lui_done: got state %0d retired %b expected 0/1", state, retired); end
    checks++; if (retire_count !== 32'(exp_count)) begin fails++; $display("[TB] FAIL lui_count: got %0d expected %0d", retire_count, exp_count); end
  endtask

  task automatic test_reset_mid();
    opcode = OP_LOAD;
    funct3 = 3'b000;
    mem_ready = 1'b0;
    step();
    step();
    step();
    checks++; if (state !== 5'd3) begin fails++; $display("[TB] FAIL midrst_pre: got %0d expected 3", state); end
    rst_n = 1'b0;
    mem_ready = 1'b1;
    step();
    rst_n = 1'b1;
    exp_count = 0;
    checks++; if (state !== 5'd0) begin fails++; $display("[TB] FAIL midrst_state: got %0d expected 0", state); end
    checks++; if (retire_count !== 32'd0 || retired !== 1'b0) begin fails++; $display("[TB] FAIL midrst_count: got count %0d retired %b expected 0/0", retire_count, retired); end
  endtask

  task automatic test_wrap();
    opcode = OP_LUI;
    mem_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      step();
      step();
      checks++; if (state !== 5'd0 || c4_retired !== 1'b1) begin fails++; $display("[TB] FAIL wrap_done[%0d]: got state %0d retired %b expected 0/1", i, state, c4_retired); end
      checks++; if (c4_count !== 4'(i % 16)) begin fails++; $display("[TB] FAIL wrap_c4_count[%0d]: got %0d expected %0d", i, c4_count, i % 16); end
      checks++; if (retire_count !== 32'(i)) begin fails++; $display("[TB] FAIL wrap_count[%0d]: got %0d expected %0d", i, retire_count, i); end
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load();
    test_branch();
    test_timeout();
    test_illegal_lui();
    test_reset_mid();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded 100000ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
